cbus_arb: RTL and testbench

- Two-master arbiter and sequencer for the 8-bit cbus register bus that feeds the register file (12-bit addr, single-cycle write strobe, fixed read latency).
- Master 0 is the EBI host bridge and master 1 is the SPI host bridge.
- Each master issues one transaction at a time. The arbiter picks a master round-robin, drives one strobe on cbus, waits out the read latency, captures read data and returns a one-cycle ack.

---
 rtl/cbus_pkg.sv | 30 +++
 rtl/cbus_arb.sv | 150 +++++++++++++++
 tb/tb_cbus_arb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbus_pkg.sv
// Shared definitions for the cbus two-master arbiter: FSM state encoding,
// default bus geometry and the round-robin picker used in IDLE.
package cbus_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  // Matches the register file read pipeline depth.
  localparam int DEF_RD_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } cbus_state_t;

  // Two-input round-robin pick: a lone requester wins outright; on a tie the
  // master that was not granted last time wins. Returns the winning id.
  function automatic logic rr_pick2(input logic req0, input logic req1,
                                    input logic last_gnt);
    logic win;
    if (req0 && req1) begin
      win = ~last_gnt;
    end else begin
      win = req1;
    end
    return win;
  endfunction

endpackage

// File: rtl/cbus_arb.sv
// Two-master arbiter/sequencer for the cbus register bus. Master 0 is the EBI
// host bridge, master 1 the SPI host bridge. One transaction is in flight at a
// time: grant, one strobe cycle, optional read-latency wait, one ack cycle.
// Every output is driven straight from a flop.
module cbus_arb
  import cbus_pkg::*;
#(
  parameter int CBUS_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CBUS_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LATENCY      = DEF_RD_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m0_req,
  input  logic                       m0_we,
  input  logic [CBUS_ADDR_WIDTH-1:0] m0_addr,
  input  logic [CBUS_DATA_WIDTH-1:0] m0_wdata,
  output logic                       m0_ack,
  output logic [CBUS_DATA_WIDTH-1:0] m0_rdata,
  input  logic                       m1_req,
  input  logic                       m1_we,
  input  logic [CBUS_ADDR_WIDTH-1:0] m1_addr,
  input  logic [CBUS_DATA_WIDTH-1:0] m1_wdata,
  output logic                       m1_ack,
  output logic [CBUS_DATA_WIDTH-1:0] m1_rdata,
  output logic [CBUS_ADDR_WIDTH-1:0] cbus_addr,
  output logic [CBUS_DATA_WIDTH-1:0] cbus_wdata,
  output logic                       cbus_we,
  output logic                       cbus_oe,
  input  logic [CBUS_DATA_WIDTH-1:0] cbus_rdata
);

  // Counter holds RD_LATENCY-1 at most; keep at least one bit for latency 1.
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LATENCY - 1);

  cbus_state_t      state;
  cbus_state_t      state_nxt;
  logic             last_gnt;
  logic             gnt_id;
  logic             gnt_we;
  logic [CNT_W-1:0] lat_cnt;

  logic             any_req;
  logic             pick;
  logic             pick_we;
  logic             grant;
  logic             lat_done;
  logic             we_nxt;
  logic             oe_nxt;
  logic             ack_nxt;
  logic             cap_rd;

  // Arbitration decode for the IDLE cycle.
  always_comb begin
    any_req  = m0_req | m1_req;
    pick     = rr_pick2(m0_req, m1_req, last_gnt);
    pick_we  = pick ? m1_we : m0_we;
    grant    = (state == ST_IDLE) && any_req;
    lat_done = (state == ST_WAIT) && (lat_cnt == '0);
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req) state_nxt = ST_STROBE;
      ST_STROBE: state_nxt = gnt_we ? ST_ACK : ST_WAIT;
      ST_WAIT:   if (lat_cnt == '0) state_nxt = ST_ACK;
      ST_ACK:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the current state.
  always_comb begin
    we_nxt  = grant && pick_we;
    oe_nxt  = grant && !pick_we;
    ack_nxt = ((state == ST_STROBE) && gnt_we) || lat_done;
    cap_rd  = lat_done;
  end

  // Output flops: strobes and acks are single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cbus_we <= 1'b0;
      cbus_oe <= 1'b0;
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
    end else begin
      cbus_we <= we_nxt;
      cbus_oe <= oe_nxt;
      m0_ack  <= ack_nxt && !gnt_id;
      m1_ack  <= ack_nxt && gnt_id;
    end
  end

  // Grant latch: the bus address/data registers double as the request latch
  // and keep their values after the transaction ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_id     <= 1'b0;
      gnt_we     <= 1'b0;
      last_gnt   <= 1'b1;
      cbus_addr  <= '0;
      cbus_wdata <= '0;
    end else if (grant) begin
      gnt_id     <= pick;
      gnt_we     <= pick_we;
      last_gnt   <= pick;
      cbus_addr  <= pick ? m1_addr : m0_addr;
      cbus_wdata <= pick ? m1_wdata : m0_wdata;
    end
  end

  // Read latency counter: loaded in the strobe cycle, counts down in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt <= '0;
    end else if (state == ST_STROBE) begin
      lat_cnt <= LAT_LOAD;
    end else if ((state == ST_WAIT) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - CNT_W'(1);
    end
  end

  // Read data capture into the granted master's holding register only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (cap_rd) begin
      if (gnt_id) begin
        m1_rdata <= cbus_rdata;
      end else begin
        m0_rdata <= cbus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cbus_arb.sv
// Directed bench for cbus_arb: a small register file model (board type at
// 0x000, 0x10 at 0x001, inverting spi_test at 0x002, scratch at 0x003) sits
// behind the default-latency DUT; a second DUT built with RD_LATENCY=1 covers
// the short-latency path.
module tb_cbus_arb;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] cbus_addr;
  logic [DW-1:0] cbus_wdata;
  logic          cbus_we, cbus_oe;
  logic [DW-1:0] cbus_rdata;

  logic          l1_m0_req = 1'b0, l1_m0_we = 1'b0;
  logic [AW-1:0] l1_m0_addr = '0;
  logic [DW-1:0] l1_m0_wdata = '0;
  logic          l1_m0_ack;
  logic [DW-1:0] l1_m0_rdata;
  logic          l1_m1_req = 1'b0, l1_m1_we = 1'b0;
  logic [AW-1:0] l1_m1_addr = '0;
  logic [DW-1:0] l1_m1_wdata = '0;
  logic          l1_m1_ack;
  logic [DW-1:0] l1_m1_rdata;
  logic [AW-1:0] l1_cbus_addr;
  logic [DW-1:0] l1_cbus_wdata;
  logic          l1_cbus_we, l1_cbus_oe;
  logic [DW-1:0] l1_cbus_rdata = 8'hEE;

  cbus_arb #(.CBUS_ADDR_WIDTH(AW), .CBUS_DATA_WIDTH(DW), .RD_LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .cbus_addr(cbus_addr), .cbus_wdata(cbus_wdata), .cbus_we(cbus_we),
    .cbus_oe(cbus_oe), .cbus_rdata(cbus_rdata)
  );

  cbus_arb #(.CBUS_ADDR_WIDTH(AW), .CBUS_DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .m0_req(l1_m0_req), .m0_we(l1_m0_we), .m0_addr(l1_m0_addr), .m0_wdata(l1_m0_wdata),
    .m0_ack(l1_m0_ack), .m0_rdata(l1_m0_rdata),
    .m1_req(l1_m1_req), .m1_we(l1_m1_we), .m1_addr(l1_m1_addr), .m1_wdata(l1_m1_wdata),
    .m1_ack(l1_m1_ack), .m1_rdata(l1_m1_rdata),
    .cbus_addr(l1_cbus_addr), .cbus_wdata(l1_cbus_wdata), .cbus_we(l1_cbus_we),
    .cbus_oe(l1_cbus_oe), .cbus_rdata(l1_cbus_rdata)
  );

  // Register file model
  logic [DW-1:0] spi_test = 8'h00;
  logic [DW-1:0] scratch  = 8'h00;
  logic [DW-1:0] rd_pipe [0:LAT-1] = '{default: 8'hEE};

  function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] a);
    case (a)
      12'h000: return 8'h01;
      12'h001: return 8'h10;
      12'h002: return ~spi_test;
      12'h003: return scratch;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cbus_we && cbus_addr == 12'h002) spi_test <= cbus_wdata;
    if (cbus_we && cbus_addr == 12'h003) scratch  <= cbus_wdata;
    rd_pipe[0] <= cbus_oe ? rf_read(cbus_addr) : 8'hEE;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign cbus_rdata = rd_pipe[LAT-1];

  always @(posedge clk) l1_cbus_rdata <= l1_cbus_oe ? rf_read(l1_cbus_addr) : 8'hEE;

  // Checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            ack_cnt0 = 0, ack_cnt1 = 0, l1_ack_cnt1 = 0, viol = 0;
  int            strobe_cyc = -1;
  logic          strobe_we = 1'b0;
  logic [AW-1:0] strobe_addr = '0;
  logic [DW-1:0] strobe_wdata = '0;
  logic          prev_strobe = 1'b0, prev_ack0 = 1'b0, prev_ack1 = 1'b0;
  int            gnt_log[$];

  always @(negedge clk) begin
    if (cbus_we && cbus_oe) viol++;
    if (m0_ack && m1_ack) viol++;
    if ((cbus_we || cbus_oe) && prev_strobe) viol++;
    if ((m0_ack && prev_ack0) || (m1_ack && prev_ack1)) viol++;
    if (l1_cbus_we && l1_cbus_oe) viol++;
    prev_strobe = cbus_we || cbus_oe;
    prev_ack0   = m0_ack;
    prev_ack1   = m1_ack;
    if (cbus_we || cbus_oe) begin
      strobe_cyc   = cyc;
      strobe_we    = cbus_we;
      strobe_addr  = cbus_addr;
      strobe_wdata = cbus_wdata;
    end
    if (m0_ack) begin ack_cnt0++; gnt_log.push_back(0); end
    if (m1_ack) begin ack_cnt1++; gnt_log.push_back(1); end
    if (l1_m1_ack) l1_ack_cnt1++;
  end

  // One master transaction: raise req, wait for ack, check timing/data, drop
  // req the cycle after ack and leave one idle cycle before returning.
  task automatic master_txn(input int m, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                            input int exp_ack, input int exp_strobe, input string tag);
    int c0;
    int ac;
    bit got;
    if (m == 0) begin m0_we = we; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1; end
    else        begin m1_we = we; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1; end
    c0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) got = 1'b1;
    end
    check({tag, " ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      ac = cyc - c0;
      if (exp_ack >= 0) check({tag, " ack_cycle"}, ac, exp_ack);
      if (exp_strobe >= 0) begin
        check({tag, " strobe_cycle"}, strobe_cyc - c0, exp_strobe);
        check({tag, " strobe_dir"}, 32'(strobe_we), 32'(we));
        check({tag, " strobe_addr"}, 32'(strobe_addr), 32'(addr));
        if (we) check({tag, " strobe_wdata"}, 32'(strobe_wdata), 32'(wd));
      end
      if (!we) check({tag, " rdata"}, 32'((m == 0) ? m0_rdata : m1_rdata), 32'(exp_rd));
    end
    @(posedge clk); #1;
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctl"}, 32'({m0_ack, m1_ack, cbus_we, cbus_oe}), 32'd0);
    check({tag, " rdata"}, 32'({m0_rdata, m1_rdata}), 32'd0);
    check({tag, " bus"}, 32'({cbus_addr, cbus_wdata}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int a0;
    bit got;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // m1 alone reads board type
    master_txn(1, 1'b0, 12'h000, 8'h00, 8'h01, 6, 1, "m1_rd_board");
    check("m1_only m0_ack_count", ack_cnt0, 0);
    check("m1_only m0_rdata", 32'(m0_rdata), 32'd0);

    // m0 write then read of inverting spi_test
    master_txn(0, 1'b1, 12'h002, 8'hA5, 8'h00, 2, 1, "m0_wr_spi");
    master_txn(0, 1'b0, 12'h002, 8'h00, 8'h5A, 6, 1, "m0_rd_spi");
    check("m0_rd_spi m1_rdata_kept", 32'(m1_rdata), 32'h01);

    // Simultaneous requests after reset: m0 first, m1 granted right after
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    gnt_log.delete();
    fork
      master_txn(0, 1'b1, 12'h003, 8'h01, 8'h00, 2, 1, "sim_m0_wr");
      master_txn(1, 1'b0, 12'h003, 8'h00, 8'h01, 9, 4, "sim_m1_rd");
    join
    check("sim grants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("sim first", gnt_log[0], 0);
      check("sim second", gnt_log[1], 1);
    end

    // Fairness with both masters re-requesting
    gnt_log.delete();
    fork
      for (int i = 0; i < 8; i++)
        master_txn(0, 1'b1, 12'h003, 8'(i + 8'h40), 8'h00, -1, -1, "fair_m0");
      for (int j = 0; j < 8; j++)
        master_txn(1, 1'b0, 12'h000, 8'h00, 8'h01, -1, -1, "fair_m1");
    join
    check("fair grants", gnt_log.size(), 16);
    for (int k = 0; k < gnt_log.size(); k++) check("fair order", gnt_log[k], k % 2);

    // Reset during WAIT of an m1 read
    a0 = ack_cnt1;
    m1_we = 1'b0; m1_addr = 12'h000; m1_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk); #1 m1_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_reset m1_no_ack", ack_cnt1, a0);

    // Post-reset simultaneous requests
    gnt_log.delete();
    fork
      master_txn(0, 1'b1, 12'h003, 8'h77, 8'h00, 2, 1, "post_m0_wr");
      master_txn(1, 1'b0, 12'h003, 8'h00, 8'h77, 9, 4, "post_m1_rd");
    join
    check("post grants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) check("post first", gnt_log[0], 0);

    // RD_LATENCY=1 build
    l1_m0_we = 1'b0; l1_m0_addr = 12'h001; l1_m0_req = 1'b1;
    c0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (l1_m0_ack) got = 1'b1;
    end
    check("lat1 ack_seen", 32'(got), 32'd1);
    check("lat1 ack_cycle", cyc - c0, 3);
    check("lat1 rdata", 32'(l1_m0_rdata), 32'h10);
    @(posedge clk); #1 l1_m0_req = 1'b0;
    repeat (3) @(posedge clk);
    check("lat1 m1_ack_count", l1_ack_cnt1, 0);

    check("bus_protocol violations", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
